// File: rtl/game_pkg.sv
// Shared game definitions: collision FSM encoding, default video geometry and
// the frame-end pixel compare used by the detector and the sprite renderers.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRACE   = 2'd1,
        ARMED   = 2'd2,
        TRIPPED = 2'd3
    } coll_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // True on the last active pixel of a frame (bottom-right corner).
    function automatic logic is_frame_end(input logic [9:0] px, input logic [9:0] py,
                                          input int h_active, input int v_active);
        return (px == 10'(h_active - 1)) && (py == 10'(v_active - 1));
    endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Per-pixel stream from the VGA sync and sprite renderers into the collision detector.
interface collision_detector_if #(
    parameter int N_OBJ = 4
);
    logic             pixel_tick;
    logic             video_on;
    logic [9:0]       x;
    logic [9:0]       y;
    logic             player_on;
    logic [N_OBJ-1:0] obstacle_on;

    modport master (output pixel_tick, video_on, x, y, player_on, obstacle_on);
    modport slave  (input  pixel_tick, video_on, x, y, player_on, obstacle_on);
endinterface

// File: rtl/collision_frame_filter.sv
// Consecutive-overlap-frame counter (saturating at 15) and the confirm compare.
module collision_frame_filter #(
    parameter int HIT_FRAMES = 2
) (
    input  logic clk,
    input  logic hard_reset_n,
    input  logic frame_end,
    input  logic frame_hit,
    input  logic clear,
    output logic confirm
);
    localparam logic [3:0] HIT_THR = 4'(HIT_FRAMES);

    logic [3:0] hit_count;
    logic [3:0] hit_count_nxt;

    always_comb begin
        hit_count_nxt = 4'd0;
        if (frame_hit) begin
            hit_count_nxt = (hit_count == 4'd15) ? 4'd15 : hit_count + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            hit_count <= 4'd0;
        end else if (clear) begin
            hit_count <= 4'd0;
        end else if (frame_end) begin
            hit_count <= hit_count_nxt;
        end
    end

    // Compare against the post-update count so the pulse lands one clk after frame end.
    assign confirm = frame_end && !clear && (hit_count_nxt >= HIT_THR);

endmodule

// File: rtl/collision_detector.sv
// Player/obstacle sprite-overlap detector with multi-frame confirmation.
// Optional COLLISION_GRACE_EN adds a GRACE_FRAMES-frame grace period before arming.
module collision_detector
    import game_pkg::*;
#(
    parameter int N_OBJ        = 4,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int HIT_FRAMES   = 2,
    parameter int GRACE_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 hard_reset_n,
    collision_detector_if.slave  pix,
    input  logic                 game_en,
    input  logic                 game_reset,
    output logic                 collision,
    output logic [N_OBJ-1:0]     collision_obj
);
    if (N_OBJ < 1 || N_OBJ > 16 || HIT_FRAMES < 1 || HIT_FRAMES > 15 ||
        GRACE_FRAMES < 1 || GRACE_FRAMES > 255) begin : g_param_check
        $error("collision_detector: parameter out of range");
    end

    coll_state_t      state;
    logic             hit_frame;
    logic [N_OBJ-1:0] frame_obj;
    logic [N_OBJ-1:0] frame_obj_nxt;
    logic             sample;
    logic             frame_end;
    logic             armed;
    logic             confirm;
    logic             filt_clear;
`ifdef COLLISION_GRACE_EN
    logic [7:0]       grace_cnt;
`endif

    assign sample        = pix.pixel_tick && pix.video_on && pix.player_on && (pix.obstacle_on != '0);
    assign frame_end     = pix.pixel_tick && pix.video_on &&
                           is_frame_end(pix.x, pix.y, H_ACTIVE, V_ACTIVE);
    assign armed         = (state == ARMED);
    // The frame-end pixel's own overlap is folded in before the frame closes.
    assign frame_obj_nxt = sample ? (frame_obj | pix.obstacle_on) : frame_obj;
    assign filt_clear    = game_reset || (armed && !game_en);

    collision_frame_filter #(.HIT_FRAMES(HIT_FRAMES)) u_filter (
        .clk          (clk),
        .hard_reset_n (hard_reset_n),
        .frame_end    (armed && frame_end),
        .frame_hit    (hit_frame || sample),
        .clear        (filt_clear),
        .confirm      (confirm)
    );

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state         <= IDLE;
            collision     <= 1'b0;
            collision_obj <= '0;
            hit_frame     <= 1'b0;
            frame_obj     <= '0;
`ifdef COLLISION_GRACE_EN
            grace_cnt     <= 8'd0;
`endif
        end else begin
            collision <= 1'b0;
            if (game_reset) begin
`ifdef COLLISION_GRACE_EN
                state     <= GRACE;
                grace_cnt <= 8'(GRACE_FRAMES);
`else
                state     <= IDLE;
`endif
                collision_obj <= '0;
                hit_frame     <= 1'b0;
                frame_obj     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_en) begin
`ifdef COLLISION_GRACE_EN
                            state     <= GRACE;
                            grace_cnt <= 8'(GRACE_FRAMES);
`else
                            state     <= ARMED;
`endif
                        end
                    end
`ifdef COLLISION_GRACE_EN
                    GRACE: begin
                        if (frame_end) begin
                            if (grace_cnt <= 8'd1) begin
                                grace_cnt <= 8'd0;
                                state     <= game_en ? ARMED : IDLE;
                            end else begin
                                grace_cnt <= grace_cnt - 8'd1;
                            end
                        end
                    end
`endif
                    ARMED: begin
                        if (!game_en) begin
                            state     <= IDLE;
                            hit_frame <= 1'b0;
                            frame_obj <= '0;
                        end else if (frame_end) begin
                            hit_frame <= 1'b0;
                            frame_obj <= '0;
                            if (confirm) begin
                                collision     <= 1'b1;
                                collision_obj <= frame_obj_nxt;
                                state         <= TRIPPED;
                            end
                        end else if (sample) begin
                            hit_frame <= 1'b1;
                            frame_obj <= frame_obj_nxt;
                        end
                    end
                    default: begin
                        // TRIPPED latches collision_obj until game_reset.
                    end
                endcase
            end
        end
    end

endmodule
